// File: rtl/i2c_apb_if.sv
// APB bus bundle between the system bus and the I2C register front-end.
//   PSEL, PENABLE, PWRITE : transfer control (setup phase, then access phase)
//   PADDR, PWDATA         : byte address and write data
//   PRDATA, PREADY        : read data and ready (always ready)
//   PSLVERR               : error response, valid in the access phase
// The master modport is the bus side; the slave modport is the register block.
interface i2c_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/i2c_apb_ctrl.sv
// APB register front-end for the I2C master engine.
// Zero-wait APB slave with TX/RX byte FIFOs, a launch/done sequencer,
// status/level reporting and a maskable, registered interrupt.
// Ports:
//   PCLK, rst     : clock (rising edge) and asynchronous active-high reset
//   apb           : APB slave port (i2c_apb_if.slave)
//   eng_start     : one-cycle launch pulse to the engine
//   eng_addr_rw   : {slave address, R/W} from the ADDR register
//   eng_cnt       : byte count from the CNT register
//   eng_done      : transfer-complete pulse from the engine
//   eng_nack      : NACK pulse from the engine (eng_done follows)
//   eng_tx_rd     : engine pops the TX FIFO
//   eng_tx_data   : TX FIFO head byte
//   eng_tx_empty  : TX FIFO empty
//   eng_rx_wr     : engine pushes eng_rx_data into the RX FIFO
//   eng_rx_data   : received byte
//   irq           : OR of enabled interrupt status bits, registered
module i2c_apb_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        PCLK,
  input  logic        rst,
  i2c_apb_if.slave    apb,
  output logic        eng_start,
  output logic [7:0]  eng_addr_rw,
  output logic [7:0]  eng_cnt,
  input  logic        eng_done,
  input  logic        eng_nack,
  input  logic        eng_tx_rd,
  output logic [7:0]  eng_tx_data,
  output logic        eng_tx_empty,
  input  logic        eng_rx_wr,
  input  logic [7:0]  eng_rx_data,
  output logic        irq
);
  localparam int LW = FIFO_AW + 1;
  localparam logic [LW-1:0]      FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]      LVL_ZERO = {LW{1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t              state_r;
  logic                eng_start_r;
  logic [7:0]          addr_r;
  logic [7:0]          cnt_r;
  logic [2:0]          irq_en_r;
  logic [LW-1:0]       rxthr_r;
  logic [3:0]          irq_stat_r;
  logic                irq_r;

  logic [7:0]          tx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  tx_wr_ptr_r;
  logic [FIFO_AW-1:0]  tx_rd_ptr_r;
  logic [LW-1:0]       tx_lvl_r;
  logic [7:0]          rx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  rx_wr_ptr_r;
  logic [FIFO_AW-1:0]  rx_rd_ptr_r;
  logic [LW-1:0]       rx_lvl_r;

  logic                access_s, wr_s, rd_s, busy_s, run_s;
  logic                ctrl_wr_s, addr_wr_s, cnt_wr_s, txd_wr_s, rxd_rd_s;
  logic                stat_wr_s, thr_wr_s, start_req_s, start_s, err_s;
  logic [31:0]         rdata_s, status_s;
  logic                tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic                tx_flush_s, rx_flush_s, tx_pop_s, rx_push_s, rx_ovf_s;
  logic [LW-1:0]       tx_lvl_nxt_s, rx_lvl_nxt_s;
  logic                rxthr_hit_s;
  logic [3:0]          irq_set_s, w1c_s;
  logic                unused_s;

  assign access_s    = apb.PSEL & apb.PENABLE;
  assign wr_s        = access_s & apb.PWRITE;
  assign rd_s        = access_s & ~apb.PWRITE;
  assign busy_s      = (state_r != ST_IDLE);
  assign run_s       = (state_r == ST_RUN);
  assign tx_full_s   = (tx_lvl_r == FULL_LVL);
  assign tx_empty_s  = (tx_lvl_r == LVL_ZERO);
  assign rx_full_s   = (rx_lvl_r == FULL_LVL);
  assign rx_empty_s  = (rx_lvl_r == LVL_ZERO);
  assign start_s     = start_req_s & ~busy_s;
  assign tx_flush_s  = ctrl_wr_s & apb.PWDATA[1];
  assign rx_flush_s  = ctrl_wr_s & apb.PWDATA[2];
  assign tx_pop_s    = eng_tx_rd & ~tx_empty_s;
  assign rx_push_s   = eng_rx_wr & ~rx_full_s;
  assign rx_ovf_s    = eng_rx_wr & rx_full_s;
  assign unused_s    = ^{apb.PADDR[31:8], apb.PWDATA[31:11]};

  // Status word assembly
  always_comb begin
    status_s              = 32'h0000_0000;
    status_s[0]           = busy_s;
    status_s[1]           = tx_full_s;
    status_s[2]           = tx_empty_s;
    status_s[3]           = rx_full_s;
    status_s[4]           = rx_empty_s;
    status_s[8 +: LW]     = tx_lvl_r;
    status_s[16 +: LW]    = rx_lvl_r;
  end

  // Address decode, read mux and error response for the access phase
  always_comb begin
    ctrl_wr_s   = 1'b0;
    addr_wr_s   = 1'b0;
    cnt_wr_s    = 1'b0;
    txd_wr_s    = 1'b0;
    rxd_rd_s    = 1'b0;
    stat_wr_s   = 1'b0;
    thr_wr_s    = 1'b0;
    start_req_s = 1'b0;
    err_s       = 1'b0;
    rdata_s     = 32'h0000_0000;
    if (access_s) begin
      case (apb.PADDR[7:0])
        8'h00: begin
          ctrl_wr_s   = wr_s;
          start_req_s = wr_s & apb.PWDATA[0];
          // A refused START still lets the flush and enable bits take effect.
          err_s       = wr_s & apb.PWDATA[0] & busy_s;
          rdata_s     = rd_s ? {21'h00_0000, irq_en_r, 8'h00} : 32'h0000_0000;
        end
        8'h04: begin
          addr_wr_s = wr_s & ~busy_s;
          err_s     = wr_s & busy_s;
          rdata_s   = rd_s ? {24'h00_0000, addr_r} : 32'h0000_0000;
        end
        8'h08: begin
          cnt_wr_s = wr_s & ~busy_s;
          err_s    = wr_s & busy_s;
          rdata_s  = rd_s ? {24'h00_0000, cnt_r} : 32'h0000_0000;
        end
        8'h0C: begin
          // Full rejects the push even if the engine pops this same cycle.
          txd_wr_s = wr_s & ~tx_full_s;
          err_s    = wr_s & tx_full_s;
        end
        8'h10: begin
          rxd_rd_s = rd_s & ~rx_empty_s;
          err_s    = rd_s & rx_empty_s;
          rdata_s  = (rd_s & ~rx_empty_s) ? {24'h00_0000, rx_mem[rx_rd_ptr_r]} : 32'h0000_0000;
        end
        8'h14: begin
          rdata_s = rd_s ? status_s : 32'h0000_0000;
        end
        8'h18: begin
          stat_wr_s = wr_s;
          rdata_s   = rd_s ? {28'h000_0000, irq_stat_r} : 32'h0000_0000;
        end
        8'h1C: begin
          thr_wr_s = wr_s;
          rdata_s  = rd_s ? 32'(rxthr_r) : 32'h0000_0000;
        end
        default: begin
          err_s = 1'b1;
        end
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Next FIFO levels; flush wins over any same-cycle push or pop
  always_comb begin
    tx_lvl_nxt_s = LVL_ZERO;
    rx_lvl_nxt_s = LVL_ZERO;
    if (tx_flush_s) begin
      tx_lvl_nxt_s = LVL_ZERO;
    end else begin
      tx_lvl_nxt_s = tx_lvl_r + {{FIFO_AW{1'b0}}, txd_wr_s} - {{FIFO_AW{1'b0}}, tx_pop_s};
    end
    if (rx_flush_s) begin
      rx_lvl_nxt_s = LVL_ZERO;
    end else begin
      rx_lvl_nxt_s = rx_lvl_r + {{FIFO_AW{1'b0}}, rx_push_s} - {{FIFO_AW{1'b0}}, rxd_rd_s};
    end
  end

  // Threshold fires only on the crossing, not while the level sits above it.
  assign rxthr_hit_s = (rxthr_r != LVL_ZERO) & (rx_lvl_nxt_s >= rxthr_r) & (rx_lvl_r < rxthr_r);
  assign irq_set_s   = {rx_ovf_s, rxthr_hit_s, eng_nack & run_s, eng_done & run_s};
  assign w1c_s       = stat_wr_s ? apb.PWDATA[3:0] : 4'h0;

  // Transfer sequencer with registered launch pulse
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      eng_start_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_LAUNCH;
            eng_start_r <= 1'b1;
          end else begin
            eng_start_r <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          state_r     <= ST_RUN;
          eng_start_r <= 1'b0;
        end
        ST_RUN: begin
          eng_start_r <= 1'b0;
          if (eng_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          eng_start_r <= 1'b0;
        end
      endcase
    end
  end

  // Configuration registers
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      addr_r   <= 8'h00;
      cnt_r    <= 8'h00;
      irq_en_r <= 3'b000;
      rxthr_r  <= LVL_ZERO;
    end else begin
      if (addr_wr_s) addr_r   <= apb.PWDATA[7:0];
      if (cnt_wr_s)  cnt_r    <= apb.PWDATA[7:0];
      if (ctrl_wr_s) irq_en_r <= apb.PWDATA[10:8];
      if (thr_wr_s)  rxthr_r  <= apb.PWDATA[LW-1:0];
    end
  end

  // Interrupt status (set beats clear) and registered interrupt line
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      irq_stat_r <= 4'h0;
      irq_r      <= 1'b0;
    end else begin
      irq_stat_r <= (irq_stat_r & ~w1c_s) | irq_set_s;
      irq_r      <= |(irq_stat_r[2:0] & irq_en_r);
    end
  end

  // TX FIFO pointers and level
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      tx_wr_ptr_r <= {FIFO_AW{1'b0}};
      tx_rd_ptr_r <= {FIFO_AW{1'b0}};
      tx_lvl_r    <= LVL_ZERO;
    end else if (tx_flush_s) begin
      tx_wr_ptr_r <= {FIFO_AW{1'b0}};
      tx_rd_ptr_r <= {FIFO_AW{1'b0}};
      tx_lvl_r    <= LVL_ZERO;
    end else begin
      if (txd_wr_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      if (tx_pop_s) tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      tx_lvl_r <= tx_lvl_nxt_s;
    end
  end

  // RX FIFO pointers and level
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_r <= {FIFO_AW{1'b0}};
      rx_rd_ptr_r <= {FIFO_AW{1'b0}};
      rx_lvl_r    <= LVL_ZERO;
    end else if (rx_flush_s) begin
      rx_wr_ptr_r <= {FIFO_AW{1'b0}};
      rx_rd_ptr_r <= {FIFO_AW{1'b0}};
      rx_lvl_r    <= LVL_ZERO;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      if (rxd_rd_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      rx_lvl_r <= rx_lvl_nxt_s;
    end
  end

  // FIFO storage; contents need no reset since the levels gate every read
  always_ff @(posedge PCLK) begin
    if (txd_wr_s) tx_mem[tx_wr_ptr_r] <= apb.PWDATA[7:0];
    if (rx_push_s & ~rx_flush_s) rx_mem[rx_wr_ptr_r] <= eng_rx_data;
  end

  assign apb.PRDATA   = rdata_s;
  assign apb.PREADY   = 1'b1;
  assign apb.PSLVERR  = err_s;
  assign eng_start    = eng_start_r;
  assign eng_addr_rw  = addr_r;
  assign eng_cnt      = cnt_r;
  assign eng_tx_data  = tx_mem[tx_rd_ptr_r];
  assign eng_tx_empty = tx_empty_s;
  assign irq          = irq_r;
endmodule

// File: tb/tb_i2c_apb_ctrl.sv
// Self-checking bench for i2c_apb_ctrl: directed scenarios followed by
// randomized APB/engine traffic, all compared against a queue-based model.
module tb_i2c_apb_ctrl;
  localparam int DEPTH = 16;

  logic PCLK = 1'b0;
  logic rst;
  always #5 PCLK = ~PCLK;

  i2c_apb_if bus ();
  logic       eng_start, eng_done, eng_nack, eng_tx_rd, eng_tx_empty, eng_rx_wr, irq;
  logic [7:0] eng_addr_rw, eng_cnt, eng_tx_data, eng_rx_data;

  i2c_apb_ctrl #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
    .PCLK(PCLK), .rst(rst), .apb(bus),
    .eng_start(eng_start), .eng_addr_rw(eng_addr_rw), .eng_cnt(eng_cnt),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_tx_rd(eng_tx_rd),
    .eng_tx_data(eng_tx_data), .eng_tx_empty(eng_tx_empty),
    .eng_rx_wr(eng_rx_wr), .eng_rx_data(eng_rx_data), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         m_phase;   // 0 idle, 1 launch cycle, 2 running
  bit         m_start, m_irq;
  logic [7:0] m_addr, m_cnt;
  logic [2:0] m_en;
  logic [4:0] m_thr;
  logic [3:0] m_stat;

  // engine stimulus for the next cycle (cleared after each cycle)
  bit         e_done, e_nack, e_txrd, e_rxwr;
  logic [7:0] e_rxdata;

  logic [31:0] last_rdata;
  bit          last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete(); rx_q.delete();
    m_phase = 0; m_start = 0; m_irq = 0;
    m_addr = 8'h00; m_cnt = 8'h00; m_en = 3'b000; m_thr = 5'd0; m_stat = 4'h0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (m_phase != 0);
    s[1]     = (tx_q.size() == DEPTH);
    s[2]     = (tx_q.size() == 0);
    s[3]     = (rx_q.size() == DEPTH);
    s[4]     = (rx_q.size() == 0);
    s[12:8]  = 5'(tx_q.size());
    s[20:16] = 5'(rx_q.size());
    return s;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, advance model, check registered outputs.
  task automatic step(input bit psel, input bit pen, input bit pwr, input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          exp_err, acc, wr, rd, busy, run, ovf, thr_hit, tx_fl, rx_fl;
    int          pre_rx, pre_tx;
    logic [3:0]  set_v, w1c_v;
    logic [23:0] hi;
    hi = 24'($urandom);
    bus.PSEL = psel; bus.PENABLE = pen; bus.PWRITE = pwr;
    bus.PADDR = {hi, a}; bus.PWDATA = wd;
    eng_done = e_done; eng_nack = e_nack; eng_tx_rd = e_txrd;
    eng_rx_wr = e_rxwr; eng_rx_data = e_rxdata;
    #1;
    acc = psel & pen; wr = acc & pwr; rd = acc & ~pwr;
    busy = (m_phase != 0); run = (m_phase == 2);
    exp_rd = 32'h0; exp_err = 1'b0;
    if (acc) begin
      case (a)
        8'h00: begin exp_err = wr & wd[0] & busy; if (rd) exp_rd = {21'h0, m_en, 8'h00}; end
        8'h04: begin exp_err = wr & busy; if (rd) exp_rd = {24'h0, m_addr}; end
        8'h08: begin exp_err = wr & busy; if (rd) exp_rd = {24'h0, m_cnt}; end
        8'h0C: exp_err = wr & (tx_q.size() == DEPTH);
        8'h10: begin
          exp_err = rd & (rx_q.size() == 0);
          if (rd && rx_q.size() > 0) exp_rd = {24'h0, rx_q[0]};
        end
        8'h14: if (rd) exp_rd = m_status();
        8'h18: if (rd) exp_rd = {28'h0, m_stat};
        8'h1C: if (rd) exp_rd = {27'h0, m_thr};
        default: exp_err = 1'b1;
      endcase
    end
    check("prdata", bus.PRDATA, exp_rd);
    check("pslverr", {31'h0, bus.PSLVERR}, {31'h0, exp_err});
    check("pready", {31'h0, bus.PREADY}, 32'h1);
    check("tx_empty", {31'h0, eng_tx_empty}, {31'h0, tx_q.size() == 0});
    if (tx_q.size() > 0) check("tx_head", {24'h0, eng_tx_data}, {24'h0, tx_q[0]});
    check("addr_rw", {24'h0, eng_addr_rw}, {24'h0, m_addr});
    check("cnt", {24'h0, eng_cnt}, {24'h0, m_cnt});
    last_rdata = bus.PRDATA; last_err = bus.PSLVERR;
    @(posedge PCLK);
    // advance the model using the pre-edge state
    m_irq   = |(m_stat[2:0] & m_en);
    m_start = 1'b0;
    tx_fl   = wr && (a == 8'h00) && wd[1];
    rx_fl   = wr && (a == 8'h00) && wd[2];
    pre_tx  = tx_q.size();
    pre_rx  = rx_q.size();
    ovf     = e_rxwr && (pre_rx == DEPTH);
    if (tx_fl) tx_q.delete();
    else begin
      if (e_txrd && pre_tx > 0) void'(tx_q.pop_front());
      if (wr && a == 8'h0C && pre_tx < DEPTH) tx_q.push_back(wd[7:0]);
    end
    if (rx_fl) rx_q.delete();
    else begin
      if (rd && a == 8'h10 && pre_rx > 0) void'(rx_q.pop_front());
      if (e_rxwr && pre_rx < DEPTH) rx_q.push_back(e_rxdata);
    end
    thr_hit = (m_thr != 0) && (rx_q.size() >= m_thr) && (pre_rx < m_thr);
    set_v   = {ovf, thr_hit, e_nack && run, e_done && run};
    w1c_v   = (wr && a == 8'h18) ? wd[3:0] : 4'h0;
    m_stat  = (m_stat & ~w1c_v) | set_v;
    if (wr && a == 8'h00) m_en = wd[10:8];
    if (wr && a == 8'h04 && !busy) m_addr = wd[7:0];
    if (wr && a == 8'h08 && !busy) m_cnt = wd[7:0];
    if (wr && a == 8'h1C) m_thr = wd[4:0];
    case (m_phase)
      0: if (wr && a == 8'h00 && wd[0]) begin m_phase = 1; m_start = 1'b1; end
      1: m_phase = 2;
      default: if (e_done) m_phase = 0;
    endcase
    #1;
    check("eng_start", {31'h0, eng_start}, {31'h0, m_start});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    e_done = 0; e_nack = 0; e_txrd = 0; e_rxwr = 0; e_rxdata = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, a, d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic apb_rd(input logic [7:0] a);
    step(1'b1, 1'b0, 1'b0, a, 32'h0);
    step(1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic eng_push(input logic [7:0] d);
    e_rxwr = 1'b1; e_rxdata = d;
    idle(1);
  endtask

  task automatic rand_eng();
    e_done   = ($urandom_range(15, 0) == 0);
    e_nack   = ($urandom_range(31, 0) == 0);
    e_txrd   = ($urandom_range(2, 0) == 0);
    e_rxwr   = ($urandom_range(2, 0) == 0);
    e_rxdata = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    bit          w;
    rst = 1'b1;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 32'h0; bus.PWDATA = 32'h0;
    eng_done = 0; eng_nack = 0; eng_tx_rd = 0; eng_rx_wr = 0; eng_rx_data = 8'h00;
    e_done = 0; e_nack = 0; e_txrd = 0; e_rxwr = 0; e_rxdata = 8'h00;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_start", {31'h0, eng_start}, 32'h0);
    check("rst_prdata", bus.PRDATA, 32'h0);
    check("rst_pslverr", {31'h0, bus.PSLVERR}, 32'h0);
    check("rst_txempty", {31'h0, eng_tx_empty}, 32'h1);
    rst = 1'b0;
    apb_rd(8'h14);
    check("rst_status", last_rdata, 32'h0000_0014);

    // basic transfer
    apb_wr(8'h04, 32'h0000_00A0);
    apb_wr(8'h08, 32'h0000_0003);
    apb_wr(8'h0C, 32'h0000_0011);
    apb_wr(8'h0C, 32'h0000_0022);
    apb_wr(8'h0C, 32'h0000_0033);
    apb_wr(8'h00, 32'h0000_0001);
    check("t1_start", {31'h0, eng_start}, 32'h1);
    check("t1_addr", {24'h0, eng_addr_rw}, 32'h0000_00A0);
    check("t1_head", {24'h0, eng_tx_data}, 32'h0000_0011);
    apb_rd(8'h14);
    check("t1_busy", last_rdata & 32'h1, 32'h1);
    for (int i = 0; i < 3; i++) begin e_txrd = 1'b1; idle(1); end
    e_done = 1'b1; idle(1);
    apb_rd(8'h14);
    check("t1_idle", last_rdata & 32'h1, 32'h0);
    apb_rd(8'h18);
    check("t1_irqstat", last_rdata, 32'h1);
    apb_wr(8'h18, 32'h0000_000F);

    // TX overflow and empty RX read
    for (int i = 0; i < DEPTH; i++) apb_wr(8'h0C, 32'($urandom_range(255, 0)));
    apb_wr(8'h0C, 32'h0000_00EE);
    check("t2_txfull_err", {31'h0, last_err}, 32'h1);
    apb_rd(8'h14);
    check("t2_txlvl", (last_rdata >> 8) & 32'h1F, 32'd16);
    check("t2_txfull", (last_rdata >> 1) & 32'h1, 32'h1);
    apb_rd(8'h10);
    check("t2_rxempty_err", {31'h0, last_err}, 32'h1);
    check("t2_rxempty_data", last_rdata, 32'h0);
    apb_wr(8'h00, 32'h0000_0002);
    apb_rd(8'h14);
    check("t2_flushed", (last_rdata >> 2) & 32'h1, 32'h1);

    // RX threshold interrupt
    apb_wr(8'h1C, 32'h0000_0004);
    apb_wr(8'h00, 32'h0000_0400);
    for (int i = 0; i < 4; i++) begin eng_push(8'hA1 + 8'(i)); idle(1); end
    check("t3_irq", {31'h0, irq}, 32'h1);
    apb_wr(8'h18, 32'h0000_0004);
    idle(1);
    check("t3_irq_clr", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      apb_rd(8'h10);
      check("t3_rxbyte", last_rdata, 32'hA1 + 32'(i));
    end
    apb_wr(8'h1C, 32'h0);
    apb_wr(8'h00, 32'h0);

    // RX overflow, simultaneous TX push+pop
    for (int i = 0; i < DEPTH; i++) eng_push(8'h40 + 8'(i));
    eng_push(8'h5A);
    apb_rd(8'h18);
    check("t4_rxovf", (last_rdata >> 3) & 32'h1, 32'h1);
    apb_rd(8'h14);
    check("t4_rxlvl", (last_rdata >> 16) & 32'h1F, 32'd16);
    for (int i = 0; i < DEPTH; i++) apb_rd(8'h10);
    check("t4_last_rx", last_rdata, 32'h0000_004F);
    apb_wr(8'h18, 32'h0000_000F);
    for (int i = 0; i < 5; i++) apb_wr(8'h0C, 32'h0000_0060 + 32'(i));
    step(1'b1, 1'b0, 1'b1, 8'h0C, 32'h0000_0077);
    e_txrd = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'h0C, 32'h0000_0077);
    apb_rd(8'h14);
    check("t4_txlvl5", (last_rdata >> 8) & 32'h1F, 32'd5);
    apb_wr(8'h00, 32'h0000_0002);

    // busy protection, nack/done, set-beats-clear
    apb_wr(8'h08, 32'h0000_0002);
    apb_wr(8'h00, 32'h0000_0001);
    apb_wr(8'h00, 32'h0000_0001);
    check("t5_start_busy", {31'h0, last_err}, 32'h1);
    apb_wr(8'h04, 32'h0000_0055);
    check("t5_addr_busy", {31'h0, last_err}, 32'h1);
    e_nack = 1'b1; idle(1);
    e_done = 1'b1; idle(1);
    apb_rd(8'h18);
    check("t5_stat", last_rdata, 32'h3);
    apb_wr(8'h00, 32'h0000_0001);
    idle(2);
    step(1'b1, 1'b0, 1'b1, 8'h18, 32'h0000_0001);
    e_done = 1'b1;
    step(1'b1, 1'b1, 1'b1, 8'h18, 32'h0000_0001);
    apb_rd(8'h18);
    check("t5_setwins", last_rdata, 32'h3);
    apb_wr(8'h18, 32'h0000_000F);

    // asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) apb_wr(8'h0C, 32'h0000_0090 + 32'(i));
    apb_wr(8'h00, 32'h0000_0201);
    idle(2);
    e_nack = 1'b1; idle(1);
    idle(1);
    check("t6_irq_pre", {31'h0, irq}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_irq_async", {31'h0, irq}, 32'h0);
    check("t6_txempty", {31'h0, eng_tx_empty}, 32'h1);
    check("t6_nostart", {31'h0, eng_start}, 32'h0);
    model_reset();
    @(posedge PCLK);
    #1 rst = 1'b0;
    apb_rd(8'h14);
    check("t6_status", last_rdata, 32'h0000_0014);

    // randomized traffic
    for (int n = 0; n < 700; n++) begin
      case ($urandom_range(9, 0))
        0: a = 8'h00; 1: a = 8'h04; 2: a = 8'h08; 3: a = 8'h0C; 4: a = 8'h10;
        5: a = 8'h14; 6: a = 8'h18; 7: a = 8'h1C; 8: a = 8'h02;
        default: a = 8'($urandom_range(255, 32));
      endcase
      w = bit'($urandom_range(1, 0));
      d = $urandom;
      if (a == 8'h00) begin
        d = d & 32'h0000_0701;
        if ($urandom_range(7, 0) == 0) d = d | ($urandom & 32'h0000_0006);
      end
      if (a == 8'h1C) d = 32'($urandom_range(DEPTH, 0));
      rand_eng();
      step(1'b1, 1'b0, w, a, d);
      rand_eng();
      step(1'b1, 1'b1, w, a, d);
      if ($urandom_range(1, 0) == 0) begin
        rand_eng();
        idle(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
